// File: rtl/mips_watchdog_timer.sv
// Watchdog down-counter loaded by the wdt_set instruction and serviced by a kick strobe.
// On expiry it raises a fixed-length reset request, then re-arms itself with the last period.
module mips_watchdog_timer #(
  parameter int DATA_WIDTH      = 32,
  parameter int COUNT_WIDTH     = 32,  // must be <= DATA_WIDTH
  parameter int RESET_PULSE_LEN = 4    // must be >= 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wait_period_w_en,
  input  logic [DATA_WIDTH-1:0]  i_wait_period,
  input  logic                   i_kick,
  output logic                   o_wdt_reset,
  output logic                   o_timeout_flag,
  output logic                   o_armed,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam int PULSE_W = (RESET_PULSE_LEN > 1) ? $clog2(RESET_PULSE_LEN) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(RESET_PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_COUNTING = 2'd1,
    ST_FIRING   = 2'd2
  } state_t;

  state_t                 state_reg,        state_next;
  logic [COUNT_WIDTH-1:0] period_reg,       period_next;
  logic [COUNT_WIDTH-1:0] count_reg,        count_next;
  logic [PULSE_W-1:0]     pulse_cnt_reg,    pulse_cnt_next;
  logic                   wdt_reset_reg,    wdt_reset_next;
  logic                   timeout_flag_reg, timeout_flag_next;
  logic                   armed_reg;

  logic [COUNT_WIDTH-1:0] period_in;
  logic                   period_is_zero;
  logic                   unused_period_bits;

  // Only the low COUNT_WIDTH bits of the register operand form the period.
  assign period_in          = i_wait_period[COUNT_WIDTH-1:0];
  assign period_is_zero     = (period_in == '0);
  assign unused_period_bits = ^i_wait_period;

  always_comb begin
    state_next        = state_reg;
    period_next       = period_reg;
    count_next        = count_reg;
    pulse_cnt_next    = pulse_cnt_reg;
    wdt_reset_next    = wdt_reset_reg;
    timeout_flag_next = timeout_flag_reg;

    unique case (state_reg)
      ST_DISARMED: begin
        if (i_wait_period_w_en) begin
          period_next = period_in;
          if (!period_is_zero) begin
            count_next = period_in;
            state_next = ST_COUNTING;
          end
        end
      end

      ST_COUNTING: begin
        if (i_wait_period_w_en && period_is_zero) begin
          count_next = '0;
          state_next = ST_DISARMED;
        end else if (i_wait_period_w_en) begin
          period_next = period_in;
          count_next  = period_in;
        end else if (i_kick) begin
          count_next = period_reg;
        end else if (count_reg == COUNT_WIDTH'(1)) begin
          // Expiry: count never wraps below 1 while counting.
          count_next        = '0;
          wdt_reset_next    = 1'b1;
          timeout_flag_next = 1'b1;
          pulse_cnt_next    = PULSE_LOAD;
          state_next        = ST_FIRING;
        end else begin
          count_next = count_reg - COUNT_WIDTH'(1);
        end
      end

      ST_FIRING: begin
        // Writes and kicks cannot shorten or cancel an in-flight reset pulse.
        if (pulse_cnt_reg != '0) begin
          pulse_cnt_next = pulse_cnt_reg - PULSE_W'(1);
        end else begin
          wdt_reset_next = 1'b0;
          count_next     = period_reg;
          state_next     = ST_COUNTING;
        end
      end

      default: begin
        state_next = ST_DISARMED;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= ST_DISARMED;
      period_reg       <= '0;
      count_reg        <= '0;
      pulse_cnt_reg    <= '0;
      wdt_reset_reg    <= 1'b0;
      timeout_flag_reg <= 1'b0;
      armed_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      period_reg       <= period_next;
      count_reg        <= count_next;
      pulse_cnt_reg    <= pulse_cnt_next;
      wdt_reset_reg    <= wdt_reset_next;
      timeout_flag_reg <= timeout_flag_next;
      armed_reg        <= (state_next != ST_DISARMED);
    end
  end

  assign o_wdt_reset    = wdt_reset_reg;
  assign o_timeout_flag = timeout_flag_reg;
  assign o_armed        = armed_reg;
  assign o_count        = count_reg;

endmodule

// File: tb/tb_mips_watchdog_timer.sv
// Scoreboard bench for mips_watchdog_timer: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_mips_watchdog_timer;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_wait_period_w_en = 1'b0;
  logic [DW-1:0] i_wait_period = '0;
  logic          i_kick = 1'b0;
  logic          o_wdt_reset;
  logic          o_timeout_flag;
  logic          o_armed;
  logic [CW-1:0] o_count;

  mips_watchdog_timer #(
    .DATA_WIDTH(DW),
    .COUNT_WIDTH(CW),
    .RESET_PULSE_LEN(PL)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_wait_period_w_en(i_wait_period_w_en),
    .i_wait_period(i_wait_period),
    .i_kick(i_kick),
    .o_wdt_reset(o_wdt_reset),
    .o_timeout_flag(o_timeout_flag),
    .o_armed(o_armed),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit flag;
    bit armed;
    int cnt;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  // Behavioural model: mode 0 = idle, 1 = watching, 2 = pulsing.
  int m_mode = 0;
  int m_period = 0;
  int m_count = 0;
  int m_pulse_left = 0;
  bit m_flag = 0;

  task automatic model_step(input bit r, input bit w, input logic [DW-1:0] p_full, input bit k);
    int p;
    p = int'(p_full % (1 << CW));
    if (r) begin
      m_mode = 0; m_period = 0; m_count = 0; m_pulse_left = 0; m_flag = 0;
    end else if (m_mode == 0) begin
      if (w) begin
        m_period = p;
        if (p > 0) begin m_count = p; m_mode = 1; end
      end
    end else if (m_mode == 1) begin
      if (w && p == 0) begin m_mode = 0; m_count = 0; end
      else if (w) begin m_period = p; m_count = p; end
      else if (k) m_count = m_period;
      else if (m_count == 1) begin
        m_mode = 2; m_count = 0; m_flag = 1; m_pulse_left = PL;
      end else m_count = m_count - 1;
    end else begin
      // Pulse spans PL cycles; leaving it reloads the remembered period.
      m_pulse_left = m_pulse_left - 1;
      if (m_pulse_left == 0) begin m_mode = 1; m_count = m_period; end
    end
  endtask

  task automatic cycle(input bit r, input bit w, input logic [DW-1:0] p, input bit k);
    exp_t e;
    @(negedge clk);
    i_reset = r; i_wait_period_w_en = w; i_wait_period = p; i_kick = k;
    model_step(r, w, p, k);
    e.rst = (m_mode == 2); e.flag = m_flag; e.armed = (m_mode != 0);
    e.cnt = m_count; e.id = txn_id;
    txn_id++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0);
  endtask

  function automatic void chk(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s txn %0d: got %0d expected %0d", name, id, act, req);
    end
  endfunction

  // Monitor: outputs are valid every cycle; compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wdt_reset", e.id, int'(o_wdt_reset), int'(e.rst));
        chk("timeout_flag", e.id, int'(o_timeout_flag), int'(e.flag));
        chk("armed", e.id, int'(o_armed), int'(e.armed));
        chk("count", e.id, int'(o_count), e.cnt);
        $display("txn %0d: rst=%0b flag=%0b armed=%0b count=%0d", e.id,
                 o_wdt_reset, o_timeout_flag, o_armed, o_count);
      end
    end
  end

  initial begin
    logic [DW-1:0] rnd;
    logic [CW-1:0] low;
    int            sel;
    int            budget;

    // Reset and kicks while disarmed
    repeat (3) cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    // Basic expiry, pulse and automatic re-arm
    cycle(0, 1, 32'd5, 0);
    idle(12);
    // Kick reloads the counter
    cycle(0, 1, 32'd5, 0);
    idle(3);
    cycle(0, 0, '0, 1);
    idle(4);
    // Write beats kick; zero write disarms
    cycle(0, 1, 32'd8, 1);
    cycle(0, 1, 32'd0, 0);
    // Writes and kicks ignored while pulsing
    cycle(0, 1, 32'd5, 0);
    idle(5);
    cycle(0, 1, 32'd3, 1);
    cycle(0, 1, 32'd3, 1);
    idle(8);
    // Reset mid-count and mid-pulse
    cycle(0, 1, 32'd5, 0);
    idle(2);
    cycle(1, 0, '0, 0);
    cycle(0, 1, 32'd2, 0);
    idle(3);
    cycle(1, 1, 32'd4, 1);
    idle(2);
    // Upper bits ignored: P=1, P=0 and all-ones
    cycle(0, 1, 32'hFFFF_FF01, 0);
    idle(7);
    cycle(0, 1, 32'hABCD_0100, 0);
    cycle(0, 1, 32'h0000_01FF, 0);
    idle(262);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom();
      sel = $urandom_range(0, 9);
      if (sel == 0) low = '0;
      else if (sel == 1) low = '1;
      else if (sel == 2) low = 8'd1;
      else low = CW'($urandom_range(2, 12));
      rnd[CW-1:0] = low;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 14) == 0), rnd,
            ($urandom_range(0, 7) == 0));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
